aes_ctr_job_scheduler: RTL

AES_CTR_JOB_SCHEDULER -- requirements
Module: aes_ctr_job_scheduler

---
 rtl/aes_ctr_job_scheduler.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_ctr_job_scheduler.sv
// Job scheduler that arbitrates XOF/PRF requests onto one AES-CTR engine and buffers its batch output.
// Optional feature: define AES_SCHED_RR_EN for round-robin arbitration (default is fixed PRF-over-XOF priority).
module aes_ctr_job_scheduler #(
   parameter int XOF_BATCHES = 3,
   parameter int PRF_BATCHES = 1,
   parameter int BATCH_W     = 2048
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               xof_req,
   input  logic [15:0]        xof_nonce,
   output logic               xof_gnt,
   input  logic               prf_req,
   input  logic [15:0]        prf_nonce,
   output logic               prf_gnt,
   output logic               eng_rst_n,
   output logic               eng_mode,
   output logic [7:0]         eng_nonce_a,
   output logic [7:0]         eng_nonce_b,
   input  logic               eng_finished,
   input  logic [BATCH_W-1:0] eng_data,
   output logic [BATCH_W-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               out_src,
   output logic               busy,
   output logic               ovf
);

   localparam int MAX_BATCHES = (XOF_BATCHES > PRF_BATCHES) ? XOF_BATCHES : PRF_BATCHES;
   localparam int CNT_W       = $clog2(MAX_BATCHES) + 1;
   localparam logic [CNT_W-1:0] XOF_LAST = CNT_W'(XOF_BATCHES);
   localparam logic [CNT_W-1:0] PRF_LAST = CNT_W'(PRF_BATCHES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t             state_r,     state_s;
   logic               xof_gnt_r,   xof_gnt_s;
   logic               prf_gnt_r,   prf_gnt_s;
   logic               eng_rst_n_r, eng_rst_n_s;
   logic               eng_mode_r,  eng_mode_s;
   logic [7:0]         nonce_a_r,   nonce_a_s;
   logic [7:0]         nonce_b_r,   nonce_b_s;
   logic [BATCH_W-1:0] out_data_r,  out_data_s;
   logic               out_valid_r, out_valid_s;
   logic               out_last_r,  out_last_s;
   logic               out_src_r,   out_src_s;
   logic               busy_r,      busy_s;
   logic               ovf_r,       ovf_s;
   logic [CNT_W-1:0]   cnt_r,       cnt_s;
   logic [CNT_W-1:0]   cnt_inc_s;
   logic [CNT_W-1:0]   target_s;
   logic               accept_s;
   logic               grant_prf_s;
   logic               any_req_s;

   assign any_req_s = xof_req | prf_req;
   assign accept_s  = out_valid_r & out_ready;
   assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
   assign target_s  = eng_mode_r ? PRF_LAST : XOF_LAST;

`ifdef AES_SCHED_RR_EN
   logic rr_ptr_r;   // 1 = PRF wins the next contention

   assign grant_prf_s = prf_req & (~xof_req | rr_ptr_r);

   // Round-robin pointer: remember which source was just served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= 1'b0;
      end else if (state_r == IDLE && any_req_s) begin
         rr_ptr_r <= ~grant_prf_s;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end
`else
   assign grant_prf_s = prf_req;
`endif

   // Next-state and next-output computation for the job FSM.
   always_comb begin
      state_s     = state_r;
      xof_gnt_s   = 1'b0;
      prf_gnt_s   = 1'b0;
      eng_rst_n_s = eng_rst_n_r;
      eng_mode_s  = eng_mode_r;
      nonce_a_s   = nonce_a_r;
      nonce_b_s   = nonce_b_r;
      out_data_s  = out_data_r;
      out_valid_s = out_valid_r;
      out_last_s  = out_last_r;
      out_src_s   = out_src_r;
      ovf_s       = ovf_r;
      cnt_s       = cnt_r;
      case (state_r)
         IDLE: begin
            eng_rst_n_s = 1'b0;
            if (any_req_s) begin
               state_s     = START;
               eng_rst_n_s = 1'b1;
               eng_mode_s  = grant_prf_s;
               out_src_s   = grant_prf_s;
               prf_gnt_s   = grant_prf_s;
               xof_gnt_s   = ~grant_prf_s;
               nonce_a_s   = grant_prf_s ? prf_nonce[15:8] : xof_nonce[15:8];
               nonce_b_s   = grant_prf_s ? prf_nonce[7:0]  : xof_nonce[7:0];
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            eng_rst_n_s = 1'b1;
            cnt_s       = {CNT_W{1'b0}};
            state_s     = RUN;
         end
         RUN: begin
            if (eng_finished) begin
               if (out_valid_r && !out_ready) begin
                  // Downstream stalled: keep the pending beat, mark it final and abort the job.
                  ovf_s       = 1'b1;
                  out_last_s  = 1'b1;
                  eng_rst_n_s = 1'b0;
                  state_s     = DRAIN;
               end else begin
                  out_data_s  = eng_data;
                  out_valid_s = 1'b1;
                  cnt_s       = cnt_inc_s;
                  if (cnt_inc_s == target_s) begin
                     out_last_s  = 1'b1;
                     eng_rst_n_s = 1'b0;
                     state_s     = DRAIN;
                  end else begin
                     out_last_s = 1'b0;
                  end
               end
            end else if (accept_s) begin
               out_valid_s = 1'b0;
               out_last_s  = 1'b0;
            end else begin
               state_s = RUN;
            end
         end
         DRAIN: begin
            eng_rst_n_s = 1'b0;
            if (accept_s || !out_valid_r) begin
               out_valid_s = 1'b0;
               out_last_s  = 1'b0;
               state_s     = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s     = IDLE;
            eng_rst_n_s = 1'b0;
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         xof_gnt_r   <= 1'b0;
         prf_gnt_r   <= 1'b0;
         eng_rst_n_r <= 1'b0;
         eng_mode_r  <= 1'b0;
         nonce_a_r   <= 8'h00;
         nonce_b_r   <= 8'h00;
         out_data_r  <= {BATCH_W{1'b0}};
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_src_r   <= 1'b0;
         busy_r      <= 1'b0;
         ovf_r       <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_s;
         xof_gnt_r   <= xof_gnt_s;
         prf_gnt_r   <= prf_gnt_s;
         eng_rst_n_r <= eng_rst_n_s;
         eng_mode_r  <= eng_mode_s;
         nonce_a_r   <= nonce_a_s;
         nonce_b_r   <= nonce_b_s;
         out_data_r  <= out_data_s;
         out_valid_r <= out_valid_s;
         out_last_r  <= out_last_s;
         out_src_r   <= out_src_s;
         busy_r      <= busy_s;
         ovf_r       <= ovf_s;
         cnt_r       <= cnt_s;
      end
   end

   assign xof_gnt     = xof_gnt_r;
   assign prf_gnt     = prf_gnt_r;
   assign eng_rst_n   = eng_rst_n_r;
   assign eng_mode    = eng_mode_r;
   assign eng_nonce_a = nonce_a_r;
   assign eng_nonce_b = nonce_b_r;
   assign out_data    = out_data_r;
   assign out_valid   = out_valid_r;
   assign out_last    = out_last_r;
   assign out_src     = out_src_r;
   assign busy        = busy_r;
   assign ovf         = ovf_r;

endmodule
